// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage.
//
// Holds the machine-wide width macros (`XLEN, `PC_WIDTH, `LOAD_WIDTH,
// `STORE_WIDTH). Each macro is guarded, so a project-level define.v
// compiled earlier takes precedence. The package also holds the
// load/store opcode constants and the bus-handshake FSM state type.
// Every other file in this slice reads these values through
// memory_stage_pkg rather than through the macros.
// No ports.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef LOAD_WIDTH
`define LOAD_WIDTH 3
`endif
`ifndef STORE_WIDTH
`define STORE_WIDTH 2
`endif

package memory_stage_pkg;

  localparam int XLEN        = `XLEN;
  localparam int LOAD_WIDTH  = `LOAD_WIDTH;
  localparam int STORE_WIDTH = `STORE_WIDTH;

  localparam logic [LOAD_WIDTH-1:0] LOAD_NONE = LOAD_WIDTH'(0);
  localparam logic [LOAD_WIDTH-1:0] LB        = LOAD_WIDTH'(1);
  localparam logic [LOAD_WIDTH-1:0] LH        = LOAD_WIDTH'(2);
  localparam logic [LOAD_WIDTH-1:0] LW        = LOAD_WIDTH'(3);
  localparam logic [LOAD_WIDTH-1:0] LBU       = LOAD_WIDTH'(4);
  localparam logic [LOAD_WIDTH-1:0] LHU       = LOAD_WIDTH'(5);

  localparam logic [STORE_WIDTH-1:0] STORE_NONE = STORE_WIDTH'(0);
  localparam logic [STORE_WIDTH-1:0] SB         = STORE_WIDTH'(1);
  localparam logic [STORE_WIDTH-1:0] SH         = STORE_WIDTH'(2);
  localparam logic [STORE_WIDTH-1:0] SW         = STORE_WIDTH'(3);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/load_align.sv
// load_align: combinational extraction and extension of load data.
//
// Ports:
//   load_op  in   load type (LB/LH/LW/LBU/LHU; NONE passes the word through)
//   lane     in   byte offset inside the word, already naturally aligned
//   rdata    in   raw word returned by the data bus
//   data     out  selected lane, sign- or zero-extended to XLEN

module load_align
  import memory_stage_pkg::*;
(
  input  logic [LOAD_WIDTH-1:0] load_op,
  input  logic [1:0]            lane,
  input  logic [XLEN-1:0]       rdata,
  output logic [XLEN-1:0]       data
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (load_op)
      LB:      data = XLEN'(byte_sel);
      LBU:     data = XLEN'($unsigned(byte_sel));
      LH:      data = XLEN'(half_sel);
      LHU:     data = XLEN'($unsigned(half_sel));
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: data-memory access stage and MW pipeline register.
//
// A load or store in the execute register issues a request on the data
// bus. The request is held, and the pipeline is stalled, until dmem_ack_i
// arrives. Load data is lane-aligned by load_align. Store data is
// replicated across byte lanes and qualified by strobes. The MW register
// captures the writeback value, or takes a bubble while the stage stalls.
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   ED_*_i                     execute-register fields (ops, data, address, dest)
//   W_bubble_i, W_stall_i      hazard-unit controls for the MW register
//   dmem_req_o/we_o/addr_o/
//   wdata_o/wstrb_o            data-bus request (word address, byte strobes)
//   dmem_rdata_i, dmem_ack_i   data-bus response
//   M_stall_o                  stall request while an access is outstanding
//   MW_valW_o/need_dstW_o/
//   dstW_o                     MW register outputs
//   M_misalign_o               misaligned-access trap (only with MISALIGN_TRAP_EN)
//
// Build option MISALIGN_TRAP_EN: when defined, misaligned halfword or word
// accesses are trapped instead of issued. When undefined, the offending
// low address bits are forced to the natural alignment.

module memory_stage
  import memory_stage_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [STORE_WIDTH-1:0] ED_store_op_i,
  input  logic [LOAD_WIDTH-1:0]  ED_load_op_i,
  input  logic                   ED_sel_reg_i,
  input  logic [XLEN-1:0]        ED_rs2_data_i,
  input  logic [XLEN-1:0]        ED_valE_i,
  input  logic                   ED_need_dstE_i,
  input  logic [4:0]             ED_dstE_i,
  input  logic                   W_bubble_i,
  input  logic                   W_stall_i,
  output logic                   dmem_req_o,
  output logic                   dmem_we_o,
  output logic [XLEN-1:0]        dmem_addr_o,
  output logic [XLEN-1:0]        dmem_wdata_o,
  output logic [3:0]             dmem_wstrb_o,
  input  logic [XLEN-1:0]        dmem_rdata_i,
  input  logic                   dmem_ack_i,
  output logic                   M_stall_o,
  output logic [XLEN-1:0]        MW_valW_o,
  output logic                   MW_need_dstW_o,
`ifdef MISALIGN_TRAP_EN
  output logic                   M_misalign_o,
`endif
  output logic [4:0]             MW_dstW_o
);

  mem_state_e      state, state_next;
  logic            is_load, is_store, mem_active, misalign;
  logic            is_half, is_word;
  logic [1:0]      lane;
  logic [XLEN-1:0] load_data, val_w;

  assign is_load    = ED_load_op_i != LOAD_NONE;
  assign is_store   = ED_store_op_i != STORE_NONE;
  assign mem_active = is_load | is_store;
  assign is_half    = (ED_load_op_i == LH) | (ED_load_op_i == LHU) | (ED_store_op_i == SH);
  assign is_word    = (ED_load_op_i == LW) | (ED_store_op_i == SW);

`ifdef MISALIGN_TRAP_EN
  assign misalign     = (is_half & ED_valE_i[0]) | (is_word & (|ED_valE_i[1:0]));
  assign lane         = ED_valE_i[1:0];
  assign M_misalign_o = misalign & ~rst_i;
`else
  assign misalign = 1'b0;
  // Force misaligned halfword/word offsets to their natural boundary.
  always_comb begin
    lane = ED_valE_i[1:0];
    if (is_word)
      lane = 2'b00;
    else if (is_half)
      lane[0] = 1'b0;
  end
`endif

  // The request drops during reset, so an access pending at reset is abandoned.
  assign dmem_req_o  = mem_active & ~misalign & ~rst_i;
  assign M_stall_o   = dmem_req_o & ~dmem_ack_i;
  assign dmem_we_o   = is_store & dmem_req_o;
  assign dmem_addr_o = {ED_valE_i[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_wstrb_o = 4'b0000;
    dmem_wdata_o = '0;
    case (ED_store_op_i)
      SB: begin
        dmem_wstrb_o = 4'b0001 << lane;
        dmem_wdata_o = {4{ED_rs2_data_i[7:0]}};
      end
      SH: begin
        dmem_wstrb_o = 4'b0011 << {lane[1], 1'b0};
        dmem_wdata_o = {2{ED_rs2_data_i[15:0]}};
      end
      SW: begin
        dmem_wstrb_o = 4'b1111;
        dmem_wdata_o = ED_rs2_data_i;
      end
      default: ;
    endcase
  end

  load_align u_load_align (
    .load_op (ED_load_op_i),
    .lane    (lane),
    .rdata   (dmem_rdata_i),
    .data    (load_data)
  );

  assign val_w = ED_sel_reg_i ? load_data : ED_valE_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // An ack that lands while MW is held keeps the FSM in WAIT. The access is
  // retired only once MW is free to capture the result.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (dmem_req_o && (!dmem_ack_i || W_stall_i)) state_next = ST_WAIT;
      ST_WAIT: if (!dmem_req_o || (dmem_ack_i && !W_stall_i)) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---- M -> W pipeline boundary ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      MW_valW_o      <= '0;
      MW_need_dstW_o <= 1'b0;
      MW_dstW_o      <= '0;
    end else if (W_bubble_i || M_stall_o || misalign) begin
      MW_valW_o      <= '0;
      MW_need_dstW_o <= 1'b0;
      MW_dstW_o      <= '0;
    end else if (!W_stall_i) begin
      MW_valW_o      <= val_w;
      MW_need_dstW_o <= ED_need_dstE_i;
      MW_dstW_o      <= ED_dstE_i;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: directed scenarios followed by randomized
// loads, stores and ALU pass-throughs. Results are checked against a
// behavioural model written with plain arithmetic.

module tb_memory_stage;

  localparam logic [2:0] L_NONE = 3'd0, L_B = 3'd1, L_H = 3'd2, L_W = 3'd3, L_BU = 3'd4, L_HU = 3'd5;
  localparam logic [1:0] S_NONE = 2'd0, S_B = 2'd1, S_H = 2'd2, S_W = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  st_op;
  logic [2:0]  ld_op;
  logic        sel;
  logic [31:0] rs2, val_e;
  logic        need;
  logic [4:0]  dst;
  logic        wbub, wstall;
  logic        req, we, ack, stall;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb;
  logic [31:0] mw_val;
  logic        mw_need;
  logic [4:0]  mw_dst;
`ifdef MISALIGN_TRAP_EN
  logic        mis_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Expected MW register contents
  logic [31:0] m_val;
  logic        m_need;
  logic [4:0]  m_dst;

  memory_stage dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ED_store_op_i  (st_op),
    .ED_load_op_i   (ld_op),
    .ED_sel_reg_i   (sel),
    .ED_rs2_data_i  (rs2),
    .ED_valE_i      (val_e),
    .ED_need_dstE_i (need),
    .ED_dstE_i      (dst),
    .W_bubble_i     (wbub),
    .W_stall_i      (wstall),
    .dmem_req_o     (req),
    .dmem_we_o      (we),
    .dmem_addr_o    (addr),
    .dmem_wdata_o   (wdata),
    .dmem_wstrb_o   (wstrb),
    .dmem_rdata_i   (rdata),
    .dmem_ack_i     (ack),
    .M_stall_o      (stall),
    .MW_valW_o      (mw_val),
    .MW_need_dstW_o (mw_need),
`ifdef MISALIGN_TRAP_EN
    .M_misalign_o   (mis_o),
`endif
    .MW_dstW_o      (mw_dst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_mw(input string tag);
    chk({tag, "_valW"}, mw_val, m_val);
    chk1({tag, "_need"}, mw_need, m_need);
    chk({tag, "_dst"}, 32'(mw_dst), 32'(m_dst));
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_half(input logic [2:0] lop, input logic [1:0] sop);
    return (lop == L_H) || (lop == L_HU) || (sop == S_H);
  endfunction

  function automatic bit is_word(input logic [2:0] lop, input logic [1:0] sop);
    return (lop == L_W) || (sop == S_W);
  endfunction

  function automatic int model_lane(input logic [2:0] lop, input logic [1:0] sop, input logic [31:0] a);
    int l;
    l = int'(a % 32'd4);
    if (is_word(lop, sop)) l = 0;
    else if (is_half(lop, sop)) l = l - (l % 2);
    return l;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] lop, input int lane, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * lane);
    case (lop)
      L_B:  begin v = v % 32'd256;   if (v >= 32'd128)   v = v + 32'hFFFFFF00; end
      L_BU: v = v % 32'd256;
      L_H:  begin v = v % 32'd65536; if (v >= 32'd32768) v = v + 32'hFFFF0000; end
      L_HU: v = v % 32'd65536;
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] sop, input int lane);
    case (sop)
      S_B: return 4'(32'd1 << lane);
      S_H: return 4'(32'd3 << lane);
      S_W: return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sop, input logic [31:0] d);
    case (sop)
      S_B: return (d % 32'd256) * 32'h01010101;
      S_H: return (d % 32'd65536) * 32'h00010001;
      S_W: return d;
      default: return 32'h0;
    endcase
  endfunction

  // One instruction: `waits` cycles without ack, then an ack cycle.
  // Entered and left at posedge+1.
  task automatic mem_txn(input logic [2:0] lop, input logic [1:0] sop, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd, input int waits,
                         input logic s, input logic n, input logic [4:0] ds, input logic bub);
    bit active;
    int lane;
    logic [31:0] vw;
    active = (lop != L_NONE) || (sop != S_NONE);
    lane   = model_lane(lop, sop, a);
    ld_op = lop; st_op = sop; val_e = a; rs2 = d; rdata = rd;
    sel = s; need = n; dst = ds; ack = 1'b0; wbub = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (active && ((is_half(lop, sop) && (a % 32'd2 != 0)) || (is_word(lop, sop) && (a % 32'd4 != 0)))) begin
      #3;
      chk1("mis_req", req, 1'b0);
      chk1("mis_flag", mis_o, 1'b1);
      @(posedge clk); #1;
      m_val = '0; m_need = 1'b0; m_dst = '0;
      chk_mw("mis_mw");
      return;
    end
`endif
    for (int w = 0; w < waits; w++) begin
      #3;
      chk1("wait_req", req, 1'(active));
      chk1("wait_stall", stall, 1'(active));
      chk("wait_addr", addr, a & 32'hFFFFFFFC);
      @(posedge clk); #1;
      m_val = '0; m_need = 1'b0; m_dst = '0;
      chk_mw("wait_mw");
    end
    ack = 1'b1; wbub = bub;
    #3;
    chk1("ack_req", req, 1'(active));
    chk1("ack_stall", stall, 1'b0);
    if (active) begin
      chk("ack_addr", addr, a & 32'hFFFFFFFC);
      chk1("ack_we", we, 1'(sop != S_NONE));
      chk("ack_wstrb", 32'(wstrb), 32'(model_strb(sop, lane)));
      chk("ack_wdata", wdata, model_wdata(sop, d));
    end
    vw = s ? model_load(lop, lane, rd) : a;
    @(posedge clk); #1;
    ack = 1'b0; wbub = 1'b0;
    if (bub) begin
      m_val = '0; m_need = 1'b0; m_dst = '0;
    end else begin
      m_val = vw; m_need = n; m_dst = ds;
    end
    chk_mw("done_mw");
  endtask

  initial begin
    rst = 1'b1; ld_op = L_NONE; st_op = S_NONE; sel = 1'b0; rs2 = '0; val_e = '0;
    need = 1'b0; dst = '0; wbub = 1'b0; wstall = 1'b0; rdata = '0; ack = 1'b0;
    m_val = '0; m_need = 1'b0; m_dst = '0;

    // Reset state, with a memory op presented during reset
    @(posedge clk); #1;
    ld_op = L_W; val_e = 32'h100; need = 1'b1; dst = 5'd3;
    #2;
    chk1("rst_req", req, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk_mw("rst_mw");
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU pass-through
    mem_txn(L_NONE, S_NONE, 32'h42, 32'h0, 32'h0, 0, 1'b0, 1'b1, 5'd7, 1'b0);
    chk("alu_lit", mw_val, 32'h00000042);
    // LW with zero-wait ack
    mem_txn(L_W, S_NONE, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1, 1'b1, 5'd5, 1'b0);
    chk("lw_lit", mw_val, 32'hDEADBEEF);
    // LB / LBU with three wait cycles
    mem_txn(L_B, S_NONE, 32'h103, 32'h0, 32'h80112233, 3, 1'b1, 1'b1, 5'd9, 1'b0);
    chk("lb_lit", mw_val, 32'hFFFFFF80);
    mem_txn(L_BU, S_NONE, 32'h103, 32'h0, 32'h80112233, 3, 1'b1, 1'b1, 5'd9, 1'b0);
    chk("lbu_lit", mw_val, 32'h00000080);
    // SH to the upper halfword
    mem_txn(L_NONE, S_H, 32'h202, 32'h0000ABCD, 32'h0, 1, 1'b0, 1'b0, 5'd0, 1'b0);
    chk1("sh_need_lit", mw_need, 1'b0);

    // Ack while MW is held: MW keeps its value and the request stays up
    mem_txn(L_NONE, S_NONE, 32'h55, 32'h0, 32'h0, 0, 1'b0, 1'b1, 5'd4, 1'b0);
    ld_op = L_W; val_e = 32'h300; rdata = 32'h12345678; sel = 1'b1; need = 1'b1; dst = 5'd11;
    ack = 1'b1; wstall = 1'b1;
    @(posedge clk); #1;
    chk_mw("wstall_hold");
    #2;
    chk1("wstall_req", req, 1'b1);
    wstall = 1'b0;
    @(posedge clk); #1;
    ack = 1'b0;
    m_val = 32'h12345678; m_need = 1'b1; m_dst = 5'd11;
    chk_mw("wstall_release");

    // Asynchronous reset clears a non-zero MW mid-cycle
    ld_op = L_NONE; sel = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    m_val = '0; m_need = 1'b0; m_dst = '0;
    chk_mw("async_rst_mw");
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset while waiting for an ack abandons the access
    ld_op = L_W; val_e = 32'h400; sel = 1'b1; need = 1'b1; dst = 5'd6;
    @(posedge clk); #1;
    #2;
    rst = 1'b1;
    #1;
    chk1("wait_rst_req", req, 1'b0);
    chk1("wait_rst_stall", stall, 1'b0);
    chk_mw("wait_rst_mw");
    @(posedge clk); #1;
    rst = 1'b0;
    ld_op = L_NONE; sel = 1'b0; val_e = '0; need = 1'b0; dst = '0; ack = 1'b1;
    #3;
    chk1("late_ack_req", req, 1'b0);
    chk1("late_ack_stall", stall, 1'b0);
    @(posedge clk); #1;
    ack = 1'b0;
    chk_mw("late_ack_mw");
    // A fresh request must still wait for its own ack
    mem_txn(L_W, S_NONE, 32'h500, 32'h0, 32'hCAFEF00D, 1, 1'b1, 1'b1, 5'd12, 1'b0);

`ifdef MISALIGN_TRAP_EN
    mem_txn(L_W, S_NONE, 32'h101, 32'h0, 32'h11111111, 0, 1'b1, 1'b1, 5'd2, 1'b0);
`endif

    // Randomized mix of loads, stores and ALU ops
    for (int i = 0; i < 60; i++) begin
      logic [2:0] lop;
      logic [1:0] sop;
      int w;
      lop = 3'($urandom_range(0, 5));
      sop = (lop == L_NONE) ? 2'($urandom_range(0, 3)) : S_NONE;
      w   = ((lop != L_NONE) || (sop != S_NONE)) ? int'($urandom_range(0, 3)) : 0;
      mem_txn(lop, sop, $urandom, $urandom, $urandom, w,
              1'(lop != L_NONE), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
